ad_ip_jesd204_tpl_adc_pack: RTL

AD_IP_JESD204_TPL_ADC_PACK -- requirements
Module: ad_ip_jesd204_tpl_adc_pack

---
 rtl/ad_ip_jesd204_tpl_adc_pack.sv | 120 ++++++++++++
 1 files changed

// File: rtl/ad_ip_jesd204_tpl_adc_pack.sv
// Packs samples of enabled ADC channels, in ascending channel order, into dense words of NUM_CHANNELS samples.
// Any change of the enable mask drops a partial word, so no word ever mixes two channel sets.
module ad_ip_jesd204_tpl_adc_pack #(
  parameter int NUM_CHANNELS      = 4,
  parameter int SAMPLE_DATA_WIDTH = 16
) (
  input  logic                                        clk,
  input  logic                                        reset,
  input  logic [NUM_CHANNELS-1:0]                     enable,
  input  logic                                        adc_valid,
  input  logic [NUM_CHANNELS*SAMPLE_DATA_WIDTH-1:0]   adc_data,
  output logic                                        adc_dovf,
  output logic                                        packed_valid,
  output logic [NUM_CHANNELS*SAMPLE_DATA_WIDTH-1:0]   packed_data,
  input  logic                                        packed_dovf
);

  localparam int N     = NUM_CHANNELS;
  localparam int W     = SAMPLE_DATA_WIDTH;
  localparam int SLOTS = 2 * N - 1;
  localparam int FW    = $clog2(N + 1);

  logic [N-1:0]   enable_q;
  logic [FW-1:0]  fill_q;
  logic [FW-1:0]  fill_d;
  logic [W-1:0]   acc_q [SLOTS];
  logic [W-1:0]   acc_d [SLOTS];
  logic [W-1:0]   comb  [SLOTS];
  logic           packed_valid_q;
  logic [N*W-1:0] packed_data_q;
  logic           adc_dovf_q;

  logic           changed;
  logic           emit;
  logic [N*W-1:0] word;
  int             fill_base;
  int             total;
  int             pre [N+1];

  always_comb begin
    changed   = (enable != enable_q);
    fill_base = changed ? 0 : int'(fill_q);

    // pre[k] is the slot offset that channel k lands on within this beat
    pre[0] = 0;
    for (int k = 0; k < N; k++) begin
      pre[k+1] = pre[k] + (enable[k] ? 1 : 0);
    end

    for (int i = 0; i < SLOTS; i++) begin
      comb[i] = (i < fill_base) ? acc_q[i] : '0;
    end
    for (int k = 0; k < N; k++) begin
      for (int i = 0; i < SLOTS; i++) begin
        if (enable[k] && (i == fill_base + pre[k])) begin
          comb[i] = adc_data[k*W +: W];
        end
      end
    end

    total = fill_base + pre[N];
    emit  = adc_valid && (total >= N);

    word = '0;
    for (int j = 0; j < N; j++) begin
      word[j*W +: W] = comb[j];
    end

    for (int i = 0; i < SLOTS; i++) begin
      acc_d[i] = acc_q[i];
    end
    fill_d = changed ? '0 : fill_q;

    if (adc_valid) begin
      if (emit) begin
        for (int i = 0; i < SLOTS; i++) begin
          acc_d[i] = '0;
        end
        for (int i = 0; i < N - 1; i++) begin
          acc_d[i] = comb[i+N];
        end
        fill_d = FW'(total - N);
      end else begin
        for (int i = 0; i < SLOTS; i++) begin
          acc_d[i] = comb[i];
        end
        fill_d = FW'(total);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      enable_q       <= '0;
      fill_q         <= '0;
      packed_valid_q <= 1'b0;
      packed_data_q  <= '0;
      adc_dovf_q     <= 1'b0;
      for (int i = 0; i < SLOTS; i++) begin
        acc_q[i] <= '0;
      end
    end else begin
      enable_q       <= enable;
      fill_q         <= fill_d;
      packed_valid_q <= emit;
      adc_dovf_q     <= packed_dovf;
      if (emit) begin
        packed_data_q <= word;
      end
      for (int i = 0; i < SLOTS; i++) begin
        acc_q[i] <= acc_d[i];
      end
    end
  end

  assign packed_valid = packed_valid_q;
  assign packed_data  = packed_data_q;
  assign adc_dovf     = adc_dovf_q;

endmodule
